// File: rtl/regbank_wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback arbiter.
// Holds the FSM encoding, the default bank geometry and the grant pointer type.
package regbank_wb_arbiter_pkg;

    localparam int unsigned DEF_DEPTH     = 15;
    localparam int unsigned DEF_WIDTH     = 32;
    localparam int unsigned DEF_ADD_WIDTH = 5;
    localparam int unsigned DROP_W        = 8;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Identifies which requester received the most recent grant
    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_t;

endpackage

// File: rtl/regbank_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered last-grant pointer.
// On a tie, the requester that was not granted most recently wins.
module rr_arb2
    import regbank_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    grant_t last;

    always_comb begin
        grant    = 2'b00;
        grant[0] = req[0] && (!req[1] || (last == GNT_B));
        grant[1] = req[1] && (!req[0] || (last == GNT_A));
    end

    // Pointer moves only when a grant is actually issued
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= GNT_B;
        end else if (grant[0]) begin
            last <= GNT_A;
        end else if (grant[1]) begin
            last <= GNT_B;
        end
    end

endmodule

// File: rtl/regbank_wb_arbiter.sv
// Register-bank write port: clears registers 1..DEPTH-1 after reset, then
// arbitrates ALU (A) and load (B) writebacks onto a single registered write port.
module regbank_wb_arbiter
    import regbank_wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned ADD_WIDTH = DEF_ADD_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [ADD_WIDTH-1:0] a_reg,
    input  logic [WIDTH-1:0]     a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [ADD_WIDTH-1:0] b_reg,
    input  logic [WIDTH-1:0]     b_data,
    output logic                 b_ready,
    output logic                 w_en,
    output logic [ADD_WIDTH-1:0] w_reg,
    output logic [WIDTH-1:0]     w_data,
    output logic                 init_done,
    output logic [DROP_W-1:0]    drop_cnt
);

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [ADD_WIDTH-1:0] cnt;
    logic [1:0]           req;
    logic [1:0]           grant;
    logic [ADD_WIDTH-1:0] sel_reg;
    logic [WIDTH-1:0]     sel_data;
    logic                 sel_legal;
    logic                 init_last;

    // Requests are only visible to the arbiter while running and out of reset
    assign req = ((state == ST_RUN) && !rst) ? {b_valid, a_valid} : 2'b00;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .grant (grant)
    );

    assign a_ready   = grant[0];
    assign b_ready   = grant[1];
    assign sel_reg   = grant[1] ? b_reg  : a_reg;
    assign sel_data  = grant[1] ? b_data : a_data;
    assign sel_legal = (sel_reg != '0) && (32'(sel_reg) < DEPTH);
    assign init_last = (cnt == ADD_WIDTH'(DEPTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: if (init_last) state_nxt = ST_RUN;
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Write port: clearing sweep in INIT, one accepted writeback per cycle in RUN
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en      <= 1'b0;
            w_reg     <= '0;
            w_data    <= '0;
            init_done <= 1'b0;
            drop_cnt  <= '0;
            cnt       <= ADD_WIDTH'(1);
        end else begin
            case (state)
                ST_INIT: begin
                    w_en   <= 1'b1;
                    w_reg  <= cnt;
                    w_data <= '0;
                    cnt    <= cnt + ADD_WIDTH'(1);
                    if (init_last) begin
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    w_en <= 1'b0;
                    if (|grant) begin
                        w_reg  <= sel_reg;
                        w_data <= sel_data;
                        if (sel_legal) begin
                            w_en <= 1'b1;
                        end else if (drop_cnt != {DROP_W{1'b1}}) begin
                            drop_cnt <= drop_cnt + DROP_W'(1);
                        end
                    end
                end
                default: begin
                    w_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Scoreboard bench for regbank_wb_arbiter: the driver queues expected write-port
// results, a negedge monitor pops and compares whenever a write or a drop appears.
module tb_regbank_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [4:0]  a_reg;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_reg;
    logic [31:0] b_data;
    logic        b_ready;
    logic        w_en;
    logic [4:0]  w_reg;
    logic [31:0] w_data;
    logic        init_done;
    logic [7:0]  drop_cnt;

    typedef struct {
        logic        en;
        logic [4:0]  r;
        logic [31:0] d;
        logic        done;
        logic [7:0]  drop;
    } exp_t;

    exp_t       q[$];
    int         total = 0;
    int         bad = 0;
    int         exp_drop = 0;
    logic       rst_q;
    logic [7:0] prev_drop;

    regbank_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a_reg     (a_reg),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_reg     (b_reg),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .w_en      (w_en),
        .w_reg     (w_reg),
        .w_data    (w_data),
        .init_done (init_done),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rst_q <= rst;

    // Monitor: every visible write or drop-count change consumes one expectation
    always @(negedge clk) begin
        if (rst_q === 1'b0 && (w_en === 1'b1 || drop_cnt !== prev_drop)) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got w_en=%0b w_reg=%0d drop=%0d, required none at %0t",
                         w_en, w_reg, drop_cnt, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("w_en", 32'(w_en), 32'(e.en));
                check("w_reg", 32'(w_reg), 32'(e.r));
                check("w_data", w_data, e.d);
                check("init_done", 32'(init_done), 32'(e.done));
                check("drop_cnt", 32'(drop_cnt), 32'(e.drop));
            end
        end
        prev_drop = drop_cnt;
    end

    // One RUN cycle with hand-computed expected grants
    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic bv, input logic [4:0] br, input logic [31:0] bd,
                         input logic ea, input logic eb);
        logic [4:0]  sr;
        logic [31:0] sd;
        a_valid = av; a_reg = ar; a_data = ad;
        b_valid = bv; b_reg = br; b_data = bd;
        #1;
        check("a_ready", 32'(a_ready), 32'(ea));
        check("b_ready", 32'(b_ready), 32'(eb));
        if (ea || eb) begin
            sr = eb ? br : ar;
            sd = eb ? bd : ad;
            if (sr != 5'd0 && sr < 5'd15) begin
                q.push_back('{1'b1, sr, sd, 1'b1, 8'(exp_drop)});
            end else if (exp_drop < 255) begin
                exp_drop++;
                q.push_back('{1'b0, sr, sd, 1'b1, 8'(exp_drop)});
            end
        end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Holds rst over one edge with both requesters pending, then checks reset values
    task automatic apply_reset();
        rst = 1'b1;
        a_valid = 1'b1; a_reg = 5'd6; a_data = 32'h1;
        b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h2;
        #1;
        check("rst_a_ready", 32'(a_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        exp_drop = 0;
        check("rst_w_en", 32'(w_en), 32'd0);
        check("rst_w_reg", 32'(w_reg), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    endtask

    // Releases reset and runs n clearing edges with requests held to prove readies stay low
    task automatic run_init(input int n);
        rst = 1'b0;
        for (int i = 1; i <= n; i++) begin
            q.push_back('{1'b1, 5'(i), 32'd0, (i == 14), 8'd0});
        end
        for (int i = 0; i < n; i++) begin
            a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h55;
            b_valid = 1'b1; b_reg = 5'd4; b_data = 32'h66;
            #1;
            check("init_a_ready", 32'(a_ready), 32'd0);
            check("init_b_ready", 32'(b_ready), 32'd0);
            @(negedge clk);
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_reg = '0; a_data = '0;
        b_valid = 1'b0; b_reg = '0; b_data = '0;

        apply_reset();
        run_init(14);

        // Tie right after INIT: A wins first, then alternation
        drive(1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd5, 32'hBBBB0005, 1'b1, 1'b0);
        drive(1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd5, 32'hBBBB0005, 1'b0, 1'b1);
        drive(1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd5, 32'hBBBB0005, 1'b1, 1'b0);
        drive(1'b1, 5'd4, 32'hAAAA0004, 1'b1, 5'd5, 32'hBBBB0005, 1'b0, 1'b1);

        drive(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678, 1'b0, 1'b1);

        // Idle cycle: write enable drops, address/data hold
        drive(1'b0, 5'd9, 32'h9, 1'b0, 5'd9, 32'h9, 1'b0, 1'b0);
        check("idle_w_en", 32'(w_en), 32'd0);
        check("idle_w_reg", 32'(w_reg), 32'd7);
        check("idle_w_data", w_data, 32'h12345678);

        // Illegal addresses: zero, above bank, exactly DEPTH
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1, 1'b0, 1'b1);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'h2, 1'b0, 1'b1);
        check("drop_after_two", 32'(drop_cnt), 32'd2);
        drive(1'b1, 5'd15, 32'h3, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 5'd14, 32'h4, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 5'd31, 32'h5, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'(i), 1'b0, 1'b1);
        end
        check("drop_saturated", 32'(drop_cnt), 32'd255);

        // Reset mid-RUN, then again mid-INIT
        drive(1'b1, 5'd9, 32'h0000_0909, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
        apply_reset();
        run_init(7);
        apply_reset();
        run_init(14);

        // Pointer returns to B on reset, so A takes the first tie again
        drive(1'b1, 5'd6, 32'h0000_0606, 1'b1, 5'd8, 32'h0000_0808, 1'b1, 1'b0);
        drive(1'b1, 5'd6, 32'h0000_0606, 1'b1, 5'd8, 32'h0000_0808, 1'b0, 1'b1);
        drive(1'b1, 5'd2, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'd0);
        check("final_init_done", 32'(init_done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regbank_wb_arbiter.md
REGBANK_WB_ARBITER -- requirements
Module: regbank_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 15, meaning number of registers in the register bank (index 0 hardwired zero).
REQ-002 SHALL have parameter WIDTH, default 32, meaning data width.
REQ-003 SHALL have parameter ADD_WIDTH, default 5, meaning register address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port a_valid  input  1  requester A (ALU writeback) has a write pending.
REQ-007 SHALL have port a_reg  input  ADD_WIDTH  requester A destination register.
REQ-008 SHALL have port a_data  input  WIDTH  requester A write data.
REQ-009 SHALL have port a_ready  output  1  requester A write accepted this cycle.
REQ-010 SHALL have ports b_valid, b_reg, b_data, b_ready with the same directions, widths and meanings for requester B (load/multi-cycle writeback).
REQ-011 SHALL have port w_en  output  1  write enable to the register bank.
REQ-012 SHALL have port w_reg  output  ADD_WIDTH  register bank write address.
REQ-013 SHALL have port w_data  output  WIDTH  register bank write data.
REQ-014 SHALL have port init_done  output  1  register bank clearing has completed.
REQ-015 SHALL have port drop_cnt  output  8  count of accepted writes discarded for an illegal address.

Function
REQ-016 SHALL implement a two-state FSM: INIT (clear bank) and RUN (arbitrate); reset enters INIT.
REQ-017 In INIT, SHALL hold a_ready=b_ready=0 and use an internal counter cnt, starting at 1.
REQ-018 In INIT, each edge SHALL register w_en=1, w_reg=cnt, w_data=0, then increment cnt.
REQ-019 On the INIT edge where cnt==DEPTH-1, SHALL also register init_done=1 and move to RUN; INIT lasts exactly DEPTH-1 edges (14 at default).
REQ-020 In RUN, a_ready and b_ready SHALL be combinational grants; a requester SHALL be granted only while its valid is high; at most one SHALL be granted per cycle.
REQ-021 If only one requester is valid in RUN, it SHALL be granted.
REQ-022 If both are valid in RUN, the one not granted most recently SHALL be granted (round-robin); the last-grant pointer SHALL update only on a grant.
REQ-023 A handshake (valid&&ready) SHALL register w_reg/w_data from the granted requester on the same edge; write latency SHALL be one cycle.
REQ-024 Registered w_en SHALL be 1 only if the granted address is nonzero and less than DEPTH; otherwise w_en=0 and drop_cnt SHALL increment, saturating at 255.
REQ-025 In RUN with no handshake, w_en SHALL be registered 0; w_reg/w_data SHALL hold their previous values.
REQ-026 Requester inputs SHALL be ignored while ready is low; requesters SHALL hold valid/reg/data until ready.
REQ-027 init_done SHALL remain 1 in RUN until the next reset.

Reset
REQ-028 On an edge with rst=1: w_en=0, w_reg=0, w_data=0, init_done=0, drop_cnt=0, cnt=1, state=INIT, last-grant=B (so A wins the first tie).
REQ-029 rst asserted mid-INIT or mid-RUN SHALL abandon current activity and restart INIT from register 1; a_ready/b_ready SHALL be 0 during rst.

Structure
REQ-030 FSM state encoding and the default DEPTH/WIDTH/ADD_WIDTH values SHALL be defined in the shared CPU package.
REQ-031 The round-robin two-way grant logic SHALL be a sub-module named rr_arb2 (inputs req[1:0], output grant[1:0], state last-grant pointer).
REQ-032 The block SHALL drive register_bank's w_en/w_reg/w_data directly, with no further glue.

Verification
REQ-033 rst 1 cycle then release -> w_reg=1..14 on consecutive cycles with w_en=1, w_data=0; init_done=1 with w_reg=14; readies 0 throughout.
REQ-034 RUN, a_valid only, a_reg=3, a_data=0xDEADBEEF -> a_ready=1 same cycle; next cycle w_en=1, w_reg=3, w_data=0xDEADBEEF.
REQ-035 RUN, both valid continuously (a_reg=4, b_reg=5) for 4 cycles -> grants A,B,A,B; w_reg 4,5,4,5.
REQ-036 RUN, b_valid with b_reg=0 then b_reg=20 -> both accepted, w_en=0 each, drop_cnt=2; 300 such writes -> drop_cnt=255.
REQ-037 rst asserted at INIT cycle 7 -> next post-reset output w_reg=1, init_done=0, drop_cnt=0.
